// File: rtl/cdb_wb_arbiter_pkg.sv
// rtl/cdb_wb_arbiter_pkg.sv - CDB writeback arbiter constants, source index type, rr helper
package cdb_wb_arbiter_pkg;

  localparam int CDB_N_SRC = 4;
  localparam int CDB_SRC_W = $clog2(CDB_N_SRC);

  typedef logic [CDB_SRC_W-1:0] cdb_src_idx_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ooop_types.sv
// rtl/ooop_types.sv - shared out-of-order pipeline types (writeback packet)
package ooop_types;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_tag;
    logic        rd_used;
    logic [6:0]  prd;
    logic [31:0] data;
  } wb_pkt_t;

endpackage

// File: rtl/cdb_wb_arbiter_fifo.sv
// rtl/cdb_wb_arbiter_fifo.sv - per-source writeback FIFO (wb_fifo), any DEPTH >= 2
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  data_in,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // a push at full only fits when the same cycle frees the head slot
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (!do_push && do_pop)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push)
      mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// rtl/cdb_wb_arbiter.sv - round-robin writeback arbiter onto a registered common data bus
module cdb_wb_arbiter
  import ooop_types::*;
  import cdb_wb_arbiter_pkg::*;
#(
  parameter int N_SRC = CDB_N_SRC,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  wb_pkt_t          wb_i [N_SRC],
  output logic [N_SRC-1:0] ready_o,
  output wb_pkt_t          cdb_o,
  output logic             overflow_o
);

  localparam int SW    = $clog2(N_SRC);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PKT_W = $bits(wb_pkt_t);

  wb_pkt_t          head  [N_SRC];
  logic [CW-1:0]    count [N_SRC];
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] empty;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    winner;
  logic             any_ne;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    logic [PKT_W-1:0] head_bits;

    assign push[k]    = wb_i[k].valid && !flush_i;
    assign pop[k]     = any_ne && !flush_i && (winner == SW'(k));
    assign head[k]    = wb_pkt_t'(head_bits);
    // conservative: ignores a same-cycle pop so the in-flight packet always fits
    assign ready_o[k] = ({1'b0, count[k]} + (CW+1)'(wb_i[k].valid)) < (CW+1)'(DEPTH);

    wb_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush_i),
      .push    (push[k]),
      .pop     (pop[k]),
      .data_in (wb_i[k]),
      .head    (head_bits),
      .count   (count[k]),
      .full    (full[k]),
      .empty   (empty[k])
    );
  end

  always_comb begin
    winner = '0;
    any_ne = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!any_ne && !empty[(int'(rr_ptr) + i) % N_SRC]) begin
        any_ne = 1'b1;
        winner = SW'((int'(rr_ptr) + i) % N_SRC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_o  <= '0;
      rr_ptr <= '0;
    end else if (flush_i) begin
      cdb_o  <= '0;
      rr_ptr <= '0;
    end else if (any_ne) begin
      cdb_o       <= head[winner];
      cdb_o.valid <= 1'b1;
      rr_ptr      <= SW'(rr_next(int'(winner), N_SRC));
    end else begin
      cdb_o <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      overflow_o <= 1'b0;
    else if (|(push & full & ~pop))
      overflow_o <= 1'b1;
  end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// tb/tb_cdb_wb_arbiter.sv - scoreboard bench for cdb_wb_arbiter against a queue-based reference model
module tb_cdb_wb_arbiter;
  import ooop_types::*;

  localparam int N = 4;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  wb_pkt_t      wb [N];
  logic [N-1:0] ready;
  wb_pkt_t      cdb;
  logic         ovf;

  typedef struct {
    wb_pkt_t pkt;
    int      cyc;
  } exp_t;

  exp_t         sb [$];
  wb_pkt_t      mq [N][$];
  int           m_rr;
  bit           m_ovf;
  int           cyc;
  bit           mon_en;
  int           n_pass;
  int           n_chk;
  exp_t         mon_e;
  wb_pkt_t      pk [N];
  wb_pkt_t      idle [N];
  wb_pkt_t      saved [3];
  logic [N-1:0] rdy;
  logic [N-1:0] prev_rdy;

  always #5 clk = ~clk;

  cdb_wb_arbiter #(.N_SRC(N), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .wb_i       (wb),
    .ready_o    (ready),
    .cdb_o      (cdb),
    .overflow_o (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic wb_pkt_t rand_pkt(input bit v);
    wb_pkt_t p;
    p.valid   = v;
    p.rob_tag = 6'($urandom);
    p.rd_used = 1'($urandom);
    p.prd     = 7'($urandom);
    p.data    = $urandom;
    return p;
  endfunction

  // CDB monitor: each broadcast must be the next expected packet, in its expected cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (cdb.valid) begin
        if (sb.size() == 0) begin
          chk("cdb_unexpected", 64'(cdb), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("cdb_pkt", 64'(cdb), 64'(mon_e.pkt));
          chk("cdb_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        chk("cdb_missing", 64'(cdb.valid), 64'(1));
      end
    end
  end

  // one cycle: drive, check combinational outputs, advance reference model at the edge
  task automatic step(input wb_pkt_t in[N], input logic fl, output logic [N-1:0] r);
    int      w;
    int      idx;
    wb_pkt_t p;
    for (int k = 0; k < N; k++) wb[k] = in[k];
    flush = fl;
    #1;
    r = ready;
    for (int k = 0; k < N; k++)
      chk($sformatf("ready%0d", k), 64'(ready[k]),
          64'((mq[k].size() + int'(in[k].valid)) < D));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    @(posedge clk);
    cyc++;
    if (fl) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      m_rr = 0;
    end else begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        idx = (m_rr + i) % N;
        if (w < 0 && mq[idx].size() > 0) w = idx;
      end
      if (w >= 0) begin
        p = mq[w].pop_front();
        sb.push_back('{pkt: p, cyc: cyc});
        m_rr = (w + 1) % N;
      end
      for (int k = 0; k < N; k++)
        if (in[k].valid) begin
          if (mq[k].size() < D) mq[k].push_back(in[k]);
          else m_ovf = 1'b1;
        end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (n) begin
      for (int k = 0; k < N; k++) wb[k] = rand_pkt(1'($urandom));
      flush = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < N; k++) begin
      wb[k] = '0;
      mq[k].delete();
    end
    sb.delete();
    m_rr   = 0;
    m_ovf  = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("reset_cdb_valid", 64'(cdb.valid), 64'(0));
    chk("reset_ready", 64'(ready), 64'(4'hF));
    chk("reset_overflow", 64'(ovf), 64'(0));
  endtask

  task automatic idle_steps(input int n);
    repeat (n) step(idle, 1'b0, rdy);
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    cyc    = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idle[k] = '0;
      wb[k]   = '0;
    end
    @(negedge clk);
    do_reset(3);

    // single packet: src 2, visible two cycles later for exactly one cycle
    pk = idle;
    pk[2] = '{valid: 1'b1, rob_tag: 6'd5, rd_used: 1'b1, prd: 7'd17, data: 32'hDEADBEEF};
    step(pk, 1'b0, rdy);
    idle_steps(1);
    chk("single_pkt", 64'(cdb), 64'(pk[2]));
    idle_steps(1);
    chk("single_one_cycle", 64'(cdb.valid), 64'(0));
    idle_steps(2);

    // contention: flush puts rr back to 0, then srcs 0,1,3 in the same cycle
    step(idle, 1'b1, rdy);
    pk = idle;
    pk[0] = rand_pkt(1'b1);
    pk[1] = rand_pkt(1'b1);
    pk[3] = rand_pkt(1'b1);
    saved[0] = pk[0];
    saved[1] = pk[1];
    saved[2] = pk[3];
    step(pk, 1'b0, rdy);
    idle_steps(1);
    chk("contend_src0", 64'(cdb), 64'(saved[0]));
    idle_steps(1);
    chk("contend_src1", 64'(cdb), 64'(saved[1]));
    idle_steps(1);
    chk("contend_src3", 64'(cdb), 64'(saved[2]));
    idle_steps(2);

    // backpressure: every source issues whenever ready was high the cycle before
    prev_rdy = '1;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < N; k++) pk[k] = rand_pkt(prev_rdy[k]);
      step(pk, 1'b0, prev_rdy);
    end
    idle_steps(6);
    chk("bp_no_overflow", 64'(ovf), 64'(0));

    // overflow: all sources valid 3 cycles from empty, rr=0 -> src2/src3 drop on the third
    step(idle, 1'b1, rdy);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) pk[k] = rand_pkt(1'b1);
      step(pk, 1'b0, rdy);
    end
    chk("ovf_set", 64'(ovf), 64'(1));
    idle_steps(1);

    // flush with a packet on src0: FIFOs emptied, flush-cycle packet never broadcast
    for (int k = 0; k < N; k++) pk[k] = rand_pkt(1'b1);
    step(pk, 1'b0, rdy);
    pk = idle;
    pk[0] = rand_pkt(1'b1);
    step(pk, 1'b1, rdy);
    #1;
    chk("flush_cdb_valid", 64'(cdb.valid), 64'(0));
    chk("flush_ready", 64'(ready), 64'(4'hF));
    chk("flush_keeps_ovf", 64'(ovf), 64'(1));
    idle_steps(4);

    // randomized traffic with occasional flushes, mostly ready-gated
    do_reset(2);
    prev_rdy = '1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        pk[k] = rand_pkt(($urandom_range(0, 3) != 0) &&
                         (prev_rdy[k] || ($urandom_range(0, 7) == 0)));
      step(pk, ($urandom_range(0, 31) == 0), prev_rdy);
    end
    idle_steps(10);
    chk("drain_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_wb_arbiter.md
Name: cdb_wb_arbiter

Overview:
- Receiving end of the FU writeback interface.
- Collects `wb_pkt_t` packets from N_SRC functional units (ALU, branch, LSU, ...) into small per-source FIFOs.
- Round-robin arbitrates them onto a single registered common data bus (CDB) that feeds ROB completion, RS wakeup and PRF write.
- Returns per-source ready so issue logic can stall FUs that have no backpressure of their own.

Parameters:
- N_SRC, 4, number of writeback sources (≥2).
- DEPTH, 2, entries per source FIFO (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush_i  in  1  pipeline flush; discards all buffered and in-flight packets.
- wb_i  in  N_SRC x $bits(ooop_types::wb_pkt_t)  writeback packet per source; enqueue when `.valid`.
- ready_o  out  N_SRC  per source: an issue this cycle is guaranteed to fit.
- cdb_o  out  $bits(ooop_types::wb_pkt_t)  registered CDB broadcast.
- overflow_o  out  1  sticky error: a valid packet was dropped because its FIFO was full.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all FIFOs empty, all counts 0, rr_ptr=0.
  - cdb_o='0, overflow_o=0.
- Enqueue:
  - at posedge, if `wb_i[k].valid` and !flush_i, the packet is written to FIFO k.
  - Accepted if count_k<DEPTH, or count_k==DEPTH and FIFO k is popped the same cycle (simultaneous push/pop at full is legal; count unchanged).
  - Otherwise the packet is dropped and overflow_o is set; it stays 1 until reset (flush does not clear it).
  - Push into an empty FIFO with no pop: count 0→1.
- ready_o[k]:
  - combinational: (count_k + wb_i[k].valid) < DEPTH.
  - Covers the one packet already in flight from a 1-cycle FU; pops are ignored (conservative).
- Arbitration, each cycle:
  - The winner is the first non-empty FIFO scanning rr_ptr, rr_ptr+1, … modulo N_SRC.
  - The winner's head is popped.
  - At posedge: cdb_o <= head, with `cdb_o.valid`=1, and rr_ptr <= (winner+1) mod N_SRC.
  - If no FIFO is non-empty: `cdb_o.valid` <= 0, other cdb_o fields <= 0, rr_ptr held.
- Packet contents (rob_tag, rd_used, prd, data) pass through unmodified; no re-zeroing of prd.
- Latency:
  - A packet valid on wb_i in cycle t, into an empty FIFO with the winning priority, appears on cdb_o in cycle t+2.
  - There is no bypass path; a packet never reaches cdb_o in the cycle it arrives.
- Throughput: one packet per cycle total.
- Fairness: any non-empty source wins within N_SRC cycles.
- Per-source ordering: FIFO order is preserved.
- Flush (flush_i=1 at posedge, rst_n=1):
  - all counts 0, read/write pointers 0, rr_ptr=0, `cdb_o.valid`<=0.
  - wb_i packets presented that cycle are discarded.
  - No pop is counted.
  - A packet already on cdb_o is visible during the flush cycle itself and is gone the next cycle.
- Reset has priority over flush; flush has priority over enqueue/dequeue.
- Pointer wrap: read/write pointers are modulo DEPTH. DEPTH need not be a power of two; compare-and-reset on wrap.

Decomposition:
- `wb_pkt_t` is already defined in ooop_types.
- Add to the package:
  - localparam CDB_N_SRC
  - an index type for source IDs
- Sub-module `wb_fifo` (one instance per source), parameter DEPTH:
  - ports: push/pop/data_in/head/count/full/empty
  - synchronous flush input
- Arbiter logic, rr_ptr and output register stay in the top module.

Test Plan:
- Reset: hold rst_n=0 3 cycles with random wb_i → cdb_o.valid=0, ready_o=all 1s, overflow_o=0 after release.
- Single packet: src 2 sends {rob_tag=5, rd_used=1, prd=17, data=0xDEADBEEF} at cycle t → identical packet on cdb_o at t+2, one cycle only.
- Contention: srcs 0,1,3 valid same cycle, rr_ptr=0 → cdb_o carries src0, src1, src3 on consecutive cycles t+2..t+4; rr_ptr ends at 0.
- Backpressure: src 0 valid every cycle, N_SRC=4, others saturated, issue gated by ready_o → no drop, overflow_o stays 0; ready_o[0] deasserts when count+valid reaches DEPTH; src0 gets ~1/4 of CDB slots.
- Overflow: force src1 valid 3 consecutive cycles while another source hogs priority, DEPTH=2 → third packet dropped, overflow_o=1 and stays 1 through a later flush.
- Flush: fill all FIFOs, assert flush_i for one cycle with wb_i[0] valid → next cycle cdb_o.valid=0, all ready_o=1, rr_ptr=0; the flush-cycle packet never appears on cdb_o.
